// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types for the execution-to-ROB writeback path.
// Holds the request payload, source indexing and round-robin helper.
package wb_arbiter_pkg;

    localparam int unsigned WB_ID_W    = 6;
    localparam int unsigned WB_DATA_W  = 32;
    localparam int unsigned WB_NUM_SRC = 3;

    typedef struct packed {
        logic [WB_ID_W-1:0]   instr_id;
        logic [WB_DATA_W-1:0] result;
        logic                 exception;
    } writeback_request_t;

    typedef enum logic [1:0] {
        WB_SRC_ALU   = 2'd0,
        WB_SRC_MUL   = 2'd1,
        WB_SRC_CACHE = 2'd2
    } wb_src_t;

    // Successor of a source in round-robin order (wraps CACHE -> ALU).
    function automatic wb_src_t wb_src_next(input wb_src_t src);
        case (src)
            WB_SRC_ALU: return WB_SRC_MUL;
            WB_SRC_MUL: return WB_SRC_CACHE;
            default:    return WB_SRC_ALU;
        endcase
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the execution pipelines, the arbiter and the ROB.
// master = pipelines/ROB side, slave = wb_arbiter.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic               flush_wb;
    logic               alu_req_valid;
    writeback_request_t alu_req_info;
    logic               mul_req_valid;
    writeback_request_t mul_req_info;
    logic               cache_req_valid;
    writeback_request_t cache_req_info;
    logic               stall_decode;
    logic               rob_req_valid;
    writeback_request_t rob_req_info;
    logic               rob_req_ready;
    logic               overflow_err;

    modport master (
        output flush_wb,
        output alu_req_valid, alu_req_info,
        output mul_req_valid, mul_req_info,
        output cache_req_valid, cache_req_info,
        output rob_req_ready,
        input  stall_decode, rob_req_valid, rob_req_info, overflow_err
    );

    modport slave (
        input  flush_wb,
        input  alu_req_valid, alu_req_info,
        input  mul_req_valid, mul_req_info,
        input  cache_req_valid, cache_req_info,
        input  rob_req_ready,
        output stall_decode, rob_req_valid, rob_req_info, overflow_err
    );

endinterface

// File: rtl/wb_fifo.sv
// Per-source writeback buffer with wrap-bit pointers.
// A push into a full buffer is kept only when a pop frees a slot in the same cycle.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  writeback_request_t       din,
    output writeback_request_t       dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    writeback_request_t mem [DEPTH];
    logic               wr_en;
    logic               rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Flush drops everything, including pushes arriving in the flush cycle.
    assign rd_en      = pop && !empty && !flush;
    assign wr_en      = push && !flush && (!full || rd_en);
    assign overflow_c = push && !flush && full && !rd_en;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU/MUL/cache writebacks into one registered ROB request per cycle,
// round-robin across per-source buffers, with a registered decode stall.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SKID       = 5
) (
    input  logic         clock,
    input  logic         reset,
    wb_arbiter_if.slave  wb
);

    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned STALL_TH = FIFO_DEPTH - SKID;

    logic [WB_NUM_SRC-1:0] src_valid;
    logic [WB_NUM_SRC-1:0] fifo_pop;
    logic [WB_NUM_SRC-1:0] fifo_empty;
    logic [WB_NUM_SRC-1:0] fifo_full;
    logic [WB_NUM_SRC-1:0] fifo_ovf_c;
    writeback_request_t    src_info  [WB_NUM_SRC];
    writeback_request_t    fifo_dout [WB_NUM_SRC];
    logic [CW-1:0]         fifo_count[WB_NUM_SRC];
    logic [CW-1:0]         cnt_nxt   [WB_NUM_SRC];

    logic               rob_valid_q, rob_valid_nxt;
    writeback_request_t rob_info_q,  rob_info_nxt;
    wb_src_t            rr_ptr_q,    rr_nxt;
    logic               stall_q,     stall_nxt;
    logic               ovf_q,       ovf_nxt;

    logic    out_free;
    logic    grant_vld;
    wb_src_t grant;
    wb_src_t cand;

    assign src_valid   = {wb.cache_req_valid, wb.mul_req_valid, wb.alu_req_valid};
    assign src_info[0] = wb.alu_req_info;
    assign src_info[1] = wb.mul_req_info;
    assign src_info[2] = wb.cache_req_info;

    for (genvar i = 0; i < WB_NUM_SRC; i++) begin : g_fifo
        wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .flush      (wb.flush_wb),
            .push       (src_valid[i]),
            .pop        (fifo_pop[i]),
            .din        (src_info[i]),
            .dout       (fifo_dout[i]),
            .empty      (fifo_empty[i]),
            .full       (fifo_full[i]),
            .count      (fifo_count[i]),
            .overflow_c (fifo_ovf_c[i])
        );
    end

    // Round-robin grant: first non-empty buffer starting at rr_ptr.
    always_comb begin
        out_free  = !rob_valid_q || wb.rob_req_ready;
        grant_vld = 1'b0;
        grant     = rr_ptr_q;
        cand      = rr_ptr_q;
        fifo_pop  = '0;
        for (int k = 0; k < WB_NUM_SRC; k++) begin
            if (!grant_vld && !fifo_empty[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
            cand = wb_src_next(cand);
        end
        if (out_free && grant_vld && !wb.flush_wb) fifo_pop[grant] = 1'b1;
    end

    // Next-state for output register, pointer, stall and sticky error.
    always_comb begin
        rob_valid_nxt = rob_valid_q;
        rob_info_nxt  = rob_info_q;
        rr_nxt        = rr_ptr_q;
        stall_nxt     = 1'b0;
        ovf_nxt       = ovf_q || (|fifo_ovf_c);
        for (int i = 0; i < WB_NUM_SRC; i++) begin
            cnt_nxt[i] = fifo_count[i]
                       + CW'(src_valid[i] && (!fifo_full[i] || fifo_pop[i]))
                       - CW'(fifo_pop[i]);
            if (cnt_nxt[i] > CW'(STALL_TH)) stall_nxt = 1'b1;
        end
        if (wb.flush_wb) begin
            rob_valid_nxt = 1'b0;
            rr_nxt        = WB_SRC_ALU;
            stall_nxt     = 1'b0;
        end else if (out_free) begin
            rob_valid_nxt = grant_vld;
            if (grant_vld) begin
                rob_info_nxt = fifo_dout[grant];
                rr_nxt       = wb_src_next(grant);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rob_valid_q <= 1'b0;
            rob_info_q  <= '0;
            rr_ptr_q    <= WB_SRC_ALU;
            stall_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            rob_valid_q <= rob_valid_nxt;
            rob_info_q  <= rob_info_nxt;
            rr_ptr_q    <= rr_nxt;
            stall_q     <= stall_nxt;
            ovf_q       <= ovf_nxt;
        end
    end

    assign wb.rob_req_valid = rob_valid_q;
    assign wb.rob_req_info  = rob_info_q;
    assign wb.stall_decode  = stall_q;
    assign wb.overflow_err  = ovf_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned SKID  = 5;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    wb_arbiter_if wb();

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .SKID(SKID)) dut (
        .clock (clock),
        .reset (reset),
        .wb    (wb)
    );

    int checks = 0;
    int errors = 0;

    logic [2:0]         in_valid;
    writeback_request_t in_info [3];
    logic               in_ready;
    logic               in_flush;

    // Reference model state
    writeback_request_t mq [3][$];
    logic               m_valid;
    writeback_request_t m_info;
    int                 m_rr;
    logic               m_stall;
    logic               m_ovf;

    int got_ids [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic writeback_request_t mk(input int id);
        writeback_request_t r;
        r.instr_id  = WB_ID_W'(id);
        r.result    = $urandom;
        r.exception = 1'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mq[i].delete();
        m_valid = 1'b0;
        m_info  = '0;
        m_rr    = 0;
        m_stall = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One clock edge of the specified behaviour: pop/grant first, then pushes.
    task automatic model_step();
        int g;
        int s;
        if (in_flush) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_valid = 1'b0;
            m_stall = 1'b0;
            m_rr    = 0;
        end else begin
            if (!m_valid || in_ready) begin
                g = -1;
                for (int k = 0; k < 3; k++) begin
                    s = (m_rr + k) % 3;
                    if (g < 0 && mq[s].size() > 0) g = s;
                end
                if (g >= 0) begin
                    m_info  = mq[g].pop_front();
                    m_valid = 1'b1;
                    m_rr    = (g + 1) % 3;
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (in_valid[i]) begin
                    if (mq[i].size() < int'(DEPTH)) mq[i].push_back(in_info[i]);
                    else m_ovf = 1'b1;
                end
            end
            m_stall = 1'b0;
            for (int i = 0; i < 3; i++)
                if (mq[i].size() > int'(DEPTH - SKID)) m_stall = 1'b1;
        end
    endtask

    task automatic compare_model();
        check_eq("valid", 64'(wb.rob_req_valid), 64'(m_valid));
        if (m_valid) check_eq("info", 64'(wb.rob_req_info), 64'(m_info));
        check_eq("stall", 64'(wb.stall_decode), 64'(m_stall));
        check_eq("overflow", 64'(wb.overflow_err), 64'(m_ovf));
    endtask

    task automatic apply();
        wb.alu_req_valid   = in_valid[0];
        wb.alu_req_info    = in_info[0];
        wb.mul_req_valid   = in_valid[1];
        wb.mul_req_info    = in_info[1];
        wb.cache_req_valid = in_valid[2];
        wb.cache_req_info  = in_info[2];
        wb.rob_req_ready   = in_ready;
        wb.flush_wb        = in_flush;
    endtask

    task automatic cycle();
        apply();
        @(posedge clock);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic idle();
        in_valid = '0;
        in_flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        in_ready = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) in_info[i] = '0;
        apply();
        model_reset();
        #12;
        check_eq("rst_valid", 64'(wb.rob_req_valid), 64'(0));
        check_eq("rst_info",  64'(wb.rob_req_info),  64'(0));
        check_eq("rst_stall", 64'(wb.stall_decode),  64'(0));
        check_eq("rst_ovf",   64'(wb.overflow_err),  64'(0));
        reset = 1'b0;

        // Single MUL request, id 5
        in_valid   = 3'b010;
        in_info[1] = mk(5);
        cycle();
        check_eq("single_early", 64'(wb.rob_req_valid), 64'(0));
        idle();
        cycle();
        check_eq("single_valid", 64'(wb.rob_req_valid), 64'(1));
        check_eq("single_id", 64'(wb.rob_req_info.instr_id), 64'(5));
        cycle();
        check_eq("single_after", 64'(wb.rob_req_valid), 64'(0));

        // Three-way burst with rr_ptr back at ALU
        in_flush = 1'b1;
        cycle();
        in_flush = 1'b0;
        in_valid = 3'b111;
        for (int i = 0; i < 3; i++) in_info[i] = mk(i + 1);
        cycle();
        idle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("burst_valid", 64'(wb.rob_req_valid), 64'(1));
            check_eq("burst_id", 64'(wb.rob_req_info.instr_id), 64'(k + 1));
        end
        cycle();
        check_eq("burst_done", 64'(wb.rob_req_valid), 64'(0));

        // Backpressure: output register occupied by id 40, then ALU fills up
        in_ready   = 1'b0;
        in_valid   = 3'b010;
        in_info[1] = mk(40);
        cycle();
        idle();
        cycle();
        for (int p = 1; p <= 9; p++) begin
            in_valid   = 3'b001;
            in_info[0] = mk(9 + p);
            cycle();
            check_eq("bp_stall", 64'(wb.stall_decode), 64'(p >= 4));
            check_eq("bp_hold", 64'(wb.rob_req_info.instr_id), 64'(40));
            check_eq("bp_ovf", 64'(wb.overflow_err), 64'(p == 9));
        end
        idle();
        in_ready = 1'b1;
        got_ids.delete();
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (wb.rob_req_valid) got_ids.push_back(int'(wb.rob_req_info.instr_id));
        end
        check_eq("drain_count", 64'(got_ids.size()), 64'(8));
        for (int k = 0; k < got_ids.size(); k++)
            check_eq("drain_order", 64'(got_ids[k]), 64'(10 + k));
        check_eq("drain_stall", 64'(wb.stall_decode), 64'(0));
        in_flush = 1'b1;
        cycle();
        in_flush = 1'b0;
        check_eq("ovf_sticky", 64'(wb.overflow_err), 64'(1));

        // Flush with all buffers loaded and a push in the flush cycle
        in_ready = 1'b0;
        in_valid = 3'b111;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 3; i++) in_info[i] = mk(20 + 3 * c + i);
            cycle();
        end
        check_eq("pre_flush_stall", 64'(wb.stall_decode), 64'(1));
        in_flush = 1'b1;
        cycle();
        check_eq("flush_valid", 64'(wb.rob_req_valid), 64'(0));
        check_eq("flush_stall", 64'(wb.stall_decode), 64'(0));
        idle();
        in_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            check_eq("post_flush_valid", 64'(wb.rob_req_valid), 64'(0));
        end

        // Asynchronous reset mid-cycle while a request is held
        in_ready   = 1'b0;
        in_valid   = 3'b001;
        in_info[0] = mk(33);
        cycle();
        idle();
        cycle();
        check_eq("pre_rst_valid", 64'(wb.rob_req_valid), 64'(1));
        #3 reset = 1'b1;
        #1;
        check_eq("arst_valid", 64'(wb.rob_req_valid), 64'(0));
        check_eq("arst_info",  64'(wb.rob_req_info),  64'(0));
        check_eq("arst_stall", 64'(wb.stall_decode),  64'(0));
        check_eq("arst_ovf",   64'(wb.overflow_err),  64'(0));
        model_reset();
        #2 reset = 1'b0;
        in_ready   = 1'b1;
        in_valid   = 3'b001;
        in_info[0] = mk(7);
        cycle();
        check_eq("rel_early", 64'(wb.rob_req_valid), 64'(0));
        idle();
        cycle();
        check_eq("rel_valid", 64'(wb.rob_req_valid), 64'(1));
        check_eq("rel_id", 64'(wb.rob_req_info.instr_id), 64'(7));

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++) begin
                in_valid[i] = ($urandom % 5) < 2;
                in_info[i]  = mk(int'($urandom % 64));
            end
            in_ready = ($urandom % 4) != 0;
            in_flush = ($urandom % 64) == 0;
            cycle();
        end
        idle();
        in_ready = 1'b1;
        for (int c = 0; c < 30; c++) cycle();
        check_eq("final_idle", 64'(wb.rob_req_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
